// File: rtl/cpu_isa_pkg.sv
// Shared CPU ISA definitions: opcode enum, register IDs, word prefixes and NOP encodings.
// Imported by the program loader and the CPU decoder.
package cpu_isa_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_MOVE  = 3'd1,
    OP_ALU   = 3'd2,
    OP_JUMP  = 3'd3,
    OP_CJUMP = 3'd4
  } op_t;

  localparam logic [2:0] REG_X0 = 3'h0;
  localparam logic [2:0] REG_X1 = 3'h1;
  localparam logic [2:0] REG_Y0 = 3'h2;
  localparam logic [2:0] REG_Y1 = 3'h3;
  localparam logic [2:0] REG_RO = 3'h4;
  localparam logic [2:0] REG_I  = 3'h5;
  localparam logic [2:0] REG_M  = 3'h6;
  localparam logic [2:0] REG_DM = 3'h7;

  localparam logic [0:0] PFX_LOAD  = 1'b0;
  localparam logic [1:0] PFX_MOVE  = 2'b10;
  localparam logic [2:0] PFX_ALU   = 3'b110;
  localparam logic [3:0] PFX_JUMP  = 4'b1110;
  localparam logic [3:0] PFX_CJUMP = 4'b1111;

  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  function automatic logic is_jump(input logic [2:0] op);
    return (op == OP_JUMP) || (op == OP_CJUMP);
  endfunction

endpackage

// File: rtl/program_loader_encoder_if.sv
// Host-side instruction handshake and program-memory write bus of the loader.
interface program_loader_encoder_if #(
  parameter int PM_ADDR_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [2:0]           in_dst;
  logic [2:0]           in_src;
  logic [3:0]           in_data;
  logic                 in_x_sel;
  logic                 in_y_sel;
  logic [2:0]           in_func;
  logic                 pm_we;
  logic [PM_ADDR_W-1:0] pm_addr;
  logic [7:0]           pm_wdata;
  logic [PM_ADDR_W:0]   wr_count;
  logic                 full;
  logic                 err_illegal;

  modport master (
    output in_valid, in_op, in_dst, in_src, in_data, in_x_sel, in_y_sel, in_func,
    input  in_ready, pm_we, pm_addr, pm_wdata, wr_count, full, err_illegal
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_src, in_data, in_x_sel, in_y_sel, in_func,
    output in_ready, pm_we, pm_addr, pm_wdata, wr_count, full, err_illegal
  );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic op + fields -> 8-bit ISA word, flags unknown opcodes.
module instr_field_packer
  import cpu_isa_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] dst,
  input  logic [2:0] src,
  input  logic [3:0] data,
  input  logic       x_sel,
  input  logic       y_sel,
  input  logic [2:0] func,
  output logic [7:0] word,
  output logic       illegal
);

  always_comb begin
    word    = 8'h00;
    illegal = 1'b0;
    case (op)
      OP_LOAD:  word = {PFX_LOAD, dst, data};
      OP_MOVE:  word = {PFX_MOVE, dst, src};
      OP_ALU:   word = {PFX_ALU, x_sel, y_sel, func};
      OP_JUMP:  word = {PFX_JUMP, data};
      OP_CJUMP: word = {PFX_CJUMP, data};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_loader_encoder.sv
// Encodes symbolic instructions and writes them to program memory at an auto-incrementing address.
// Optional NOP_PAD_EN: a NOP pad word follows every JUMP/CJUMP.
module program_loader_encoder
  import cpu_isa_pkg::*;
#(
  parameter int         PM_ADDR_W = 8,
  parameter logic [7:0] NOP_WORD  = 8'hC8
) (
  input logic                    clk,
  input logic                    async_reset_n,
  input logic                    clear,
  program_loader_encoder_if.slave bus
);

`ifdef NOP_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE} state_t;
`endif

  localparam logic [PM_ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [PM_ADDR_W-1:0] PTR_ONE   = PM_ADDR_W'(1);
  localparam logic [PM_ADDR_W:0]   CNT_ONE   = (PM_ADDR_W + 1)'(1);

  state_t               state;
  logic [PM_ADDR_W-1:0] ptr;
  logic [PM_ADDR_W-1:0] addr_r;
  logic [7:0]           wdata_r;
  logic [PM_ADDR_W:0]   cnt_r;
  logic                 we_r;
  logic                 full_r;
  logic                 err_r;
  logic [7:0]           word;
  logic                 illegal;
  logic                 accept;

  instr_field_packer u_packer (
    .op      (bus.in_op),
    .dst     (bus.in_dst),
    .src     (bus.in_src),
    .data    (bus.in_data),
    .x_sel   (bus.in_x_sel),
    .y_sel   (bus.in_y_sel),
    .func    (bus.in_func),
    .word    (word),
    .illegal (illegal)
  );

  assign bus.in_ready    = async_reset_n && (state == S_IDLE) && !full_r && !clear;
  assign accept          = bus.in_valid && bus.in_ready;
  // clear arriving while a word is on the bus kills the strobe in that same cycle
  assign bus.pm_we       = we_r && !clear;
  assign bus.pm_addr     = addr_r;
  assign bus.pm_wdata    = wdata_r;
  assign bus.wr_count    = cnt_r;
  assign bus.full        = full_r;
  assign bus.err_illegal = err_r;

`ifdef NOP_PAD_EN
  logic jump_r;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) jump_r <= 1'b0;
    else if (accept)    jump_r <= is_jump(bus.in_op);
  end
`else
  logic unused_nop_word;
  assign unused_nop_word = ^NOP_WORD;
`endif

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= accept && illegal;
      if (clear) begin
        state  <= S_IDLE;
        we_r   <= 1'b0;
        ptr    <= '0;
        cnt_r  <= '0;
        full_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && !illegal) begin
              state   <= S_WRITE;
              we_r    <= 1'b1;
              addr_r  <= ptr;
              wdata_r <= word;
            end
          end
          S_WRITE: begin
            cnt_r <= cnt_r + CNT_ONE;
            state <= S_IDLE;
            we_r  <= 1'b0;
            // the pointer parks on the last address instead of wrapping
            if (ptr == LAST_ADDR) begin
              full_r <= 1'b1;
            end else begin
              ptr <= ptr + PTR_ONE;
`ifdef NOP_PAD_EN
              if (jump_r) begin
                state   <= S_PAD;
                we_r    <= 1'b1;
                addr_r  <= ptr + PTR_ONE;
                wdata_r <= NOP_WORD;
              end
`endif
            end
          end
`ifdef NOP_PAD_EN
          S_PAD: begin
            cnt_r <= cnt_r + CNT_ONE;
            state <= S_IDLE;
            we_r  <= 1'b0;
            if (ptr == LAST_ADDR) full_r <= 1'b1;
            else                  ptr    <= ptr + PTR_ONE;
          end
`endif
          default: begin
            state <= S_IDLE;
            we_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader_encoder.sv
// Scoreboard bench for program_loader_encoder: reference model pushes expected writes, monitor pops on pm_we.
module tb_program_loader_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic async_reset_n;
  logic clear;

  always #5 clk = ~clk;

  program_loader_encoder_if #(.PM_ADDR_W(AW)) bus ();

  program_loader_encoder #(.PM_ADDR_W(AW), .NOP_WORD(8'hC8)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .clear         (clear),
    .bus           (bus)
  );

  typedef struct {
    int addr;
    int word;
    int cnt;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  ptr, cnt, busy;
  bit  mfull, err_next, exp_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA word from its bit-field definition, written as plain arithmetic
  function automatic int encode(int op, int dst, int src, int data, int x, int y, int func);
    case (op)
      0:       return dst * 16 + data;
      1:       return 128 + dst * 8 + src;
      2:       return 192 + x * 16 + y * 8 + func;
      3:       return 224 + data;
      4:       return 240 + data;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    ptr = 0; cnt = 0; mfull = 1'b0; busy = 0;
  endtask

  task automatic push(input int w);
    wr_t e;
    e.addr = ptr; e.word = w; e.cnt = cnt;
    sb.push_back(e);
    cnt++;
    if (ptr == DEPTH - 1) mfull = 1'b1;
    else                  ptr++;
  endtask

  task automatic model_accept(input int op, input int dst, input int src, input int data,
                              input int x, input int y, input int func);
    int w;
    w = encode(op, dst, src, data, x, y, func);
    if (w < 0) begin
      err_next = 1'b1;
    end else begin
      push(w);
      busy = 2;
      if (PAD_EN && (op == 3 || op == 4) && !mfull) begin
        push(8'hC8);
        busy = 3;
      end
    end
  endtask

  task automatic step(input bit v, input int op, input int dst, input int src, input int data,
                      input int x, input int y, input int func, input bit clr);
    bit exp_rdy;
    @(posedge clk);
    if (busy > 0) busy--;
    exp_err  = err_next;
    err_next = 1'b0;
    #1;
    bus.in_valid = v;
    bus.in_op    = 3'(op);
    bus.in_dst   = 3'(dst);
    bus.in_src   = 3'(src);
    bus.in_data  = 4'(data);
    bus.in_x_sel = 1'(x);
    bus.in_y_sel = 1'(y);
    bus.in_func  = 3'(func);
    clear        = clr;
    if (clr) model_reset();
    #1;
    exp_rdy = !clr && (busy == 0) && !mfull;
    chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
    if (busy == 0 && !clr) begin
      chk("full", int'(bus.full), int'(mfull));
      chk("wr_count_idle", int'(bus.wr_count), cnt);
    end
    if (v && exp_rdy) model_accept(op, dst, src, data, x, y, func);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic rnd_step(input bit v, input int op, input bit clr);
    step(v, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), clr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pm_we"}, int'(bus.pm_we), 0);
    chk({tag, "_pm_addr"}, int'(bus.pm_addr), 0);
    chk({tag, "_pm_wdata"}, int'(bus.pm_wdata), 0);
    chk({tag, "_wr_count"}, int'(bus.wr_count), 0);
    chk({tag, "_full"}, int'(bus.full), 0);
    chk({tag, "_err_illegal"}, int'(bus.err_illegal), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic reset_mid_write();
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();
    step(1'b1, 0, 2, 0, 5, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk("pm_we_before_reset", int'(bus.pm_we), 1);
    bus.in_valid  = 1'b0;
    async_reset_n = 1'b0;
    model_reset();
    err_next = 1'b0;
    exp_err  = 1'b0;
    #1;
    check_reset_outputs("midwrite_reset");
    @(posedge clk);
    #1;
    async_reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.pm_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h, expected no write", bus.pm_addr, bus.pm_wdata);
      end else begin
        e = sb.pop_front();
        chk("pm_addr", int'(bus.pm_addr), e.addr);
        chk("pm_wdata", int'(bus.pm_wdata), e.word);
        chk("wr_count_write", int'(bus.wr_count), e.cnt);
      end
    end
    chk("err_illegal", int'(bus.err_illegal), int'(exp_err));
  end

  initial begin
    async_reset_n = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_dst    = '0;
    bus.in_src    = '0;
    bus.in_data   = '0;
    bus.in_x_sel  = 1'b0;
    bus.in_y_sel  = 1'b0;
    bus.in_func   = '0;
    model_reset();
    err_next = 1'b0;
    exp_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    async_reset_n = 1'b1;

    // directed sequences from the datasheet examples
    step(1'b1, 0, 6, 0, 9, 0, 0, 0, 1'b0);
    idle();
    step(1'b1, 1, 4, 4, 0, 0, 0, 0, 1'b0);
    step(1'b1, 2, 0, 0, 0, 1, 1, 7, 1'b0);
    idle();
    step(1'b1, 2, 0, 0, 0, 1, 1, 7, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 6, 1, 2, 3, 0, 0, 0, 1'b0);
    step(1'b1, 0, 1, 0, 4, 0, 0, 0, 1'b0);
    idle();
    idle();
    step(1'b1, 3, 0, 0, 3, 0, 0, 0, 1'b0);
    repeat (3) idle();
    step(1'b1, 4, 0, 0, 5, 0, 0, 0, 1'b0);
    repeat (3) idle();

    // stream LOADs into a full memory, then clear and write again at 0
    repeat (2 * DEPTH + 4) rnd_step(1'b1, 0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 0, 3, 0, 10, 0, 0, 0, 1'b0);
    repeat (2) idle();

    // jumps landing near the top address to exercise pad/full interplay
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      repeat (DEPTH - 2 + k % 2) begin
        rnd_step(1'b1, 0, 1'b0);
        idle();
      end
      rnd_step(1'b1, 3 + k / 2, 1'b0);
      repeat (4) idle();
    end

    for (int i = 0; i < 700; i++) begin
      rnd_step(($urandom_range(0, 9) < 7), $urandom_range(0, 7), ($urandom_range(0, 29) == 0));
    end
    repeat (4) idle();

    reset_mid_write();
    step(1'b1, 0, 7, 0, 1, 0, 0, 0, 1'b0);
    repeat (4) idle();

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
